pe_array_seq_ctrl: RTL and testbench



---
 rtl/pe_array_pkg.sv | 7 +
 rtl/pe_seq_addr_gen.sv | 58 +++++
 rtl/pe_array_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_pe_array_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared state encoding, slot type and latency default for the PE array sequencer.
package pe_array_pkg;
    localparam int SLOT_W     = 4;
    localparam int PE_LAT_DEF = 2;
    typedef logic [SLOT_W-1:0] slot_t;
    typedef enum logic [2:0] {IDLE, MAC, DRAIN, ROUND, WAIT, OUT, DONE} seq_state_e;
endpackage

// File: rtl/pe_seq_addr_gen.sv
// pe_seq_addr_gen: operand read address, step/slot counters and last-read flag for one tile.
module pe_seq_addr_gen #(
    parameter int AW     = 10,
    parameter int KW     = 8,
    parameter int SLOT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [KW-1:0]     cfg_k_i,
    input  logic [AW-1:0]     cfg_base_i,
    input  logic [SLOT_W-1:0] slots_i,
    output logic [AW-1:0]     addr_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              last_o
);
    logic [AW-1:0]     addr_q, addr_d;
    logic [KW-1:0]     k_q, k_d, klim_q, klim_d;
    logic [SLOT_W-1:0] s_q, s_d;
    logic              k_end;

    assign k_end  = k_q == klim_q - KW'(1);
    assign last_o = k_end && s_q == slots_i;
    assign addr_o = addr_q;
    assign slot_o = s_q;

    always_comb begin
        addr_d = addr_q;
        k_d    = k_q;
        s_d    = s_q;
        klim_d = klim_q;
        if (load_i) begin
            addr_d = cfg_base_i;
            k_d    = '0;
            s_d    = '0;
            klim_d = cfg_k_i;
        end else if (step_i) begin
            addr_d = addr_q + AW'(1);
            k_d    = k_end ? '0 : k_q + KW'(1);
            s_d    = k_end ? s_q + SLOT_W'(1) : s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            k_q    <= '0;
            s_q    <= '0;
            klim_q <= '0;
        end else begin
            addr_q <= addr_d;
            k_q    <= k_d;
            s_q    <= s_d;
            klim_q <= klim_d;
        end
    end
endmodule

// File: rtl/pe_array_seq_ctrl.sv
// pe_array_seq_ctrl: streams operand rows into the 2x16 PE array, drains, rounds each slot and hands results downstream.
// Optional perf counters (perf_cycles, perf_stall) are built when PE_ARRAY_SEQ_PERF_CNT_EN is defined.
module pe_array_seq_ctrl #(
    parameter int AW     = 10,
    parameter int KW     = 8,
    parameter int SLOT_W = pe_array_pkg::SLOT_W,
    parameter int PE_LAT = pe_array_pkg::PE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     cfg_k,
    input  logic [SLOT_W-1:0] cfg_slots,
    input  logic [AW-1:0]     cfg_base,
    output logic              busy,
    output logic              done,
    output logic              buf_rd_en,
    output logic [AW-1:0]     buf_rd_addr,
    output logic              pe_mac_en,
    output logic [SLOT_W-1:0] pe_add_number,
    output logic              pe_rounder_en,
    output logic [SLOT_W-1:0] pe_rounder_number,
    output logic              out_valid,
    output logic [SLOT_W-1:0] out_slot,
    input  logic              out_ready
`ifdef PE_ARRAY_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);
    import pe_array_pkg::*;

    localparam int CW = $clog2(PE_LAT + 1) + 1;

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SLOT_W-1:0] r_q, r_d, slots_q, slots_d, rd_slot, add_q;
    logic              mac_q, accept, last_rd, last_r;

    assign accept = state_q == IDLE && start;
    assign last_r = r_q == slots_q;

    pe_seq_addr_gen #(.AW(AW), .KW(KW), .SLOT_W(SLOT_W)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .step_i     (buf_rd_en),
        .cfg_k_i    (cfg_k),
        .cfg_base_i (cfg_base),
        .slots_i    (slots_q),
        .addr_o     (buf_rd_addr),
        .slot_o     (rd_slot),
        .last_o     (last_rd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        slots_d = slots_q;
        unique case (state_q)
            IDLE: if (start) begin
                slots_d = cfg_slots;
                r_d     = '0;
                state_d = cfg_k == '0 ? DONE : MAC;
            end
            MAC: if (last_rd) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            // PE_LAT+1 cycles so the final MAC, issued one cycle after its read, has settled
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PE_LAT)) begin
                    state_d = ROUND;
                    r_d     = '0;
                end
            end
            ROUND: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PE_LAT - 1)) state_d = OUT;
            end
            OUT: if (out_ready) begin
                state_d = last_r ? DONE : ROUND;
                r_d     = last_r ? r_q : r_q + SLOT_W'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            slots_q <= '0;
            mac_q   <= 1'b0;
            add_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            slots_q <= slots_d;
            mac_q   <= buf_rd_en;
            add_q   <= rd_slot;
        end
    end

    assign busy              = state_q != IDLE;
    assign done              = state_q == DONE;
    assign buf_rd_en         = state_q == MAC;
    assign pe_mac_en         = mac_q;
    assign pe_add_number     = add_q;
    assign pe_rounder_en     = state_q == ROUND;
    assign pe_rounder_number = pe_rounder_en ? r_q : '0;
    assign out_valid         = state_q == OUT;
    assign out_slot          = out_valid ? r_q : '0;

`ifdef PE_ARRAY_SEQ_PERF_CNT_EN
    logic [31:0] pcyc_q, pstall_q;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            pcyc_q   <= '0;
            pstall_q <= '0;
        end else begin
            if (busy && ~&pcyc_q) pcyc_q <= pcyc_q + 32'd1;
            if (out_valid && !out_ready && ~&pstall_q) pstall_q <= pstall_q + 32'd1;
        end
    end

    assign perf_cycles = pcyc_q;
    assign perf_stall  = pstall_q;
`endif
endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// tb_pe_array_seq_ctrl: directed tiles with a scoreboard of expected reads, MAC slots, rounds and results.
module tb_pe_array_seq_ctrl;
    localparam int AW  = 10;
    localparam int KW  = 8;
    localparam int SW  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [KW-1:0] cfg_k = '0;
    logic [SW-1:0] cfg_slots = '0;
    logic [AW-1:0] cfg_base = '0;
    logic          busy, done, buf_rd_en, pe_mac_en, pe_rounder_en, out_valid;
    logic [AW-1:0] buf_rd_addr;
    logic [SW-1:0] pe_add_number, pe_rounder_number, out_slot;
`ifdef PE_ARRAY_SEQ_PERF_CNT_EN
    logic [31:0]   perf_cycles, perf_stall;
`endif

    int total = 0, bad = 0;
    int q_addr[$], q_mac[$], q_rnd[$], q_out[$];
    int mac_cnt = 0, rnd_cnt = 0, cyc_ctr = 0, rnd_cyc = 0, dcyc;
    logic          prev_rd = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [SW-1:0] prev_slot = '0;
    logic [31:0]   e_v;

    always #5 clk = ~clk;

    pe_array_seq_ctrl #(.AW(AW), .KW(KW), .SLOT_W(SW), .PE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_slots(cfg_slots), .cfg_base(cfg_base),
        .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .pe_mac_en(pe_mac_en), .pe_add_number(pe_add_number),
        .pe_rounder_en(pe_rounder_en), .pe_rounder_number(pe_rounder_number),
        .out_valid(out_valid), .out_slot(out_slot), .out_ready(out_ready)
`ifdef PE_ARRAY_SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc_ctr++;
            if (rst) begin
                prev_rd    = 1'b0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (buf_rd_en) begin
                    e_v = 'x;
                    if (q_addr.size() > 0) e_v = q_addr.pop_front();
                    chk("rd_addr", 32'(buf_rd_addr), e_v);
                end
                if (pe_mac_en || prev_rd) chk("mac_lag", 32'(pe_mac_en), 32'(prev_rd));
                if (pe_mac_en) begin
                    mac_cnt++;
                    e_v = 'x;
                    if (q_mac.size() > 0) e_v = q_mac.pop_front();
                    chk("mac_slot", 32'(pe_add_number), e_v);
                end
                if (pe_rounder_en) begin
                    rnd_cnt++;
                    rnd_cyc = cyc_ctr;
                    e_v = 'x;
                    if (q_rnd.size() > 0) e_v = q_rnd.pop_front();
                    chk("rnd_slot", 32'(pe_rounder_number), e_v);
                end
                if (out_valid) chk("rnd_during_out", 32'(pe_rounder_en), 32'd0);
                if (out_valid && !prev_valid) chk("out_lat", 32'(cyc_ctr - rnd_cyc), 32'(LAT + 1));
                if (prev_valid && !prev_ready) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_slot", 32'(out_slot), 32'(prev_slot));
                end
                if (out_valid && out_ready) begin
                    e_v = 'x;
                    if (q_out.size() > 0) e_v = q_out.pop_front();
                    chk("out_slot", 32'(out_slot), e_v);
                end
                prev_rd    = buf_rd_en;
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_slot  = out_slot;
            end
        end
    endtask

    task automatic push_exp(input int base, input int k, input int sl);
        for (int s = 0; s <= sl; s++) begin
            for (int j = 0; j < k; j++) begin
                q_addr.push_back((base + s * k + j) & ((1 << AW) - 1));
                q_mac.push_back(s);
            end
            if (k != 0) begin
                q_rnd.push_back(s);
                q_out.push_back(s);
            end
        end
    endtask

    task automatic run_tile(input int base, input int k, input int sl, input int stall, input int glitch,
                            output int d);
        int  cyc, sleft;
        bit  seen;
        push_exp(base, k, sl);
        mac_cnt   = 0;
        rnd_cnt   = 0;
        cfg_base  = AW'(base);
        cfg_k     = KW'(k);
        cfg_slots = SW'(sl);
        out_ready = stall == 0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc   = 0;
        seen  = 0;
        sleft = stall;
        d     = -1;
        while (!seen && cyc < 20000) begin
            if (cyc == glitch) begin
                start     = 1'b1;
                cfg_base  = AW'(base + 7);
                cfg_k     = KW'(k + 1);
                cfg_slots = SW'(sl + 1);
            end
            out_ready = sleft == 0;
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_rise", 32'(busy), 32'd1);
            if (out_valid && !out_ready) sleft--;
            if (done) begin
                seen = 1;
                d    = cyc;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("rd_left", 32'(q_addr.size()), 32'd0);
        chk("mac_left", 32'(q_mac.size()), 32'd0);
        chk("rnd_left", 32'(q_rnd.size()), 32'd0);
        chk("out_left", 32'(q_out.size()), 32'd0);
        chk("mac_count", 32'(mac_cnt), 32'((sl + 1) * k));
        chk("rnd_count", 32'(rnd_cnt), k != 0 ? 32'(sl + 1) : 32'd0);
`ifdef PE_ARRAY_SEQ_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, 32'(d));
        chk("perf_stall", perf_stall, 32'(stall));
`endif
    endtask

    initial begin
        int dn;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
        chk("rst_mac_en", 32'(pe_mac_en), 32'd0);
        chk("rst_rnd_en", 32'(pe_rounder_en), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_tile('h010, 3, 1, 0, -1, dcyc);
        run_tile('h3FE, 4, 0, 0, -1, dcyc);
        run_tile('h020, 2, 1, 5, -1, dcyc);
        run_tile('h055, 0, 3, 0, -1, dcyc);
        chk("k0_done_lat", 32'(dcyc), 32'd1);
        run_tile('h100, 4, 1, 0, 3, dcyc);

        push_exp('h200, 5, 2);
        cfg_base  = AW'('h200);
        cfg_k     = KW'(5);
        cfg_slots = SW'(2);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_en", 32'(buf_rd_en), 32'd0);
        chk("abort_rd_addr", 32'(buf_rd_addr), 32'd0);
        chk("abort_mac_en", 32'(pe_mac_en), 32'd0);
        chk("abort_add_num", 32'(pe_add_number), 32'd0);
        chk("abort_rnd_en", 32'(pe_rounder_en), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        q_addr.delete();
        q_mac.delete();
        q_rnd.delete();
        q_out.delete();
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        @(posedge clk);
        #1;

        run_tile('h3FE, 4, 0, 0, -1, dcyc);
        run_tile('h001, 255, 15, 0, -1, dcyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
